store_unit: RTL and testbench
=============================

// Module: store_unit
// PURPOSE
//   Write-side partner of the load path: accepts SW/SH/SB requests from the MEM
//   stage, checks alignment, and builds byte strobes plus lane-replicated write
//   data. Requests queue in a small in-order FIFO and are issued one at a time
//   on the SRAM-like data write port (req/addr_ok/data_ok).
// PARAMETERS
//   DEPTH  2  store FIFO entries; power of two, >= 2
// PORTS
//   clk            in   1   clock
//   reset          in   1   synchronous reset, active-high
//   st_valid       in   1   store request valid
//   st_ready       out  1   FIFO can accept (= !full, registered state)
//   st_type        in   2   0=SW, 1=SH, 2=SB, 3=reserved (treated as SW)
//   st_addr        in   32  byte address
//   st_data        in   32  register data (byte/half in low bits)
//   st_ades        out  1   combinational misalign flag for current request
//   data_req       out  1   write request to memory
//   data_wr        out  1   1 whenever data_req=1, else 0
//   data_size      out  2   0=byte, 1=half, 2=word
//   data_addr      out  32  byte address (st_addr unmodified)
//   data_wstrb     out  4   byte enables
//   data_wdata     out  32  lane-replicated write data
//   data_addr_ok   in   1   request accepted
//   data_data_ok   in   1   write completed
//   busy           out  1   FIFO non-empty or write in flight
// BEHAVIOUR
//   - Reset: FIFO empty, state IDLE; data_req=0, data_wr=0, busy=0, st_ready=1.
//   - Alignment: st_ades = st_valid & ((SH & addr[0]) | (SW & addr[1:0]!=0)).
//   - Push when st_valid & st_ready & !st_ades; misaligned requests never queued.
//   - Encode at push: SB wstrb=4'b0001<<addr[1:0], wdata={4{data[7:0]}};
//     SH wstrb=addr[1]?1100:0011, wdata={2{data[15:0]}}; SW wstrb=1111, wdata=data.
//   - st_ready from registered count only: full blocks push even if pop same cycle.
//   - Push+pop same cycle on non-full FIFO: count unchanged, order preserved.
//   - FSM IDLE: FIFO non-empty -> REQ (earliest data_req = cycle after push).
//   - REQ: data_req=1, payload = FIFO head, held stable until data_addr_ok;
//     data_addr_ok -> WAIT.
//   - WAIT: data_req=0; data_data_ok -> pop head; -> REQ if entries remain,
//     else IDLE. One outstanding write max.
//   - data_data_ok outside WAIT and data_addr_ok outside REQ are ignored.
//   - Reset mid-operation: FIFO flushed, in-flight write abandoned; memory side
//     is reset in the same cycle.
// CONFIGURATION
//   STORE_UNIT_HAZARD_EN defined: adds ports ld_addr (in, 32) and ld_hazard
//   (out, 1); ld_hazard = combinational OR over all valid entries (including
//   in-flight head) of entry.addr[31:2]==ld_addr[31:2]; pipeline stalls the load.
//   Undefined: both ports absent; no compare logic.
// TESTING
//   1. SB addr 0x1003 data 0x000000A5 -> data_wstrb=1000, data_wdata=A5A5A5A5, size=0.
//   2. SH addr 0x1001 -> st_ades=1; no push; data_req stays 0, busy=0.
//   3. Two SW with data_addr_ok low -> st_ready=0 after 2nd push; release ->
//      issue in push order, st_ready=1 after first data_data_ok.
//   4. data_addr_ok low 5 cycles -> data_req, addr, wstrb, wdata constant throughout.
//   5. reset asserted in WAIT -> next cycle data_req=0, busy=0, st_ready=1.
//   6. (HAZARD_EN) SW 0x2000 queued, ld_addr=0x2002 -> ld_hazard=1;
//      cleared cycle after data_data_ok pops it; ld_addr=0x2004 -> 0.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: queues aligned SW/SH/SB requests, encodes strobes and
// lane-replicated data, and issues them in order on the data write port.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   st_valid/ready    store request handshake from MEM
//   st_type/addr/data store request payload
//   st_ades           combinational misalign flag
//   data_*            SRAM-like write port (req/addr_ok/data_ok)
//   busy              FIFO non-empty or write in flight
// Optional macro STORE_UNIT_HAZARD_EN adds ld_addr / ld_hazard, which flag
// a load that hits the same word as any queued store.
module store_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ades,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        busy
`ifdef STORE_UNIT_HAZARD_EN
    ,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   mem_addr  [DEPTH];
    logic [1:0]    mem_size  [DEPTH];
    logic [3:0]    mem_wstrb [DEPTH];
    logic [31:0]   mem_wdata [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          full, push, pop;

    logic [1:0]    enc_size;
    logic [3:0]    enc_wstrb;
    logic [31:0]   enc_wdata;
    logic          is_sh, is_sw;

    // Reserved type 3 behaves exactly like SW.
    assign is_sh   = (st_type == 2'd1);
    assign is_sw   = (st_type == 2'd0) || (st_type == 2'd3);
    assign st_ades = st_valid &
                     ((is_sh & st_addr[0]) |
                      (is_sw & (st_addr[1:0] != 2'b00)));

    // st_ready comes from registered count only, so a full FIFO refuses
    // a push even when the head retires in the same cycle.
    assign full     = (count == (AW+1)'(DEPTH));
    assign st_ready = !full;
    assign push     = st_valid & st_ready & !st_ades;
    assign pop      = (state == WAIT) & data_data_ok;

    always_comb begin
        enc_size  = 2'd2;
        enc_wstrb = 4'b1111;
        enc_wdata = st_data;
        case (st_type)
            2'd1: begin
                enc_size  = 2'd1;
                enc_wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
                enc_wdata = {2{st_data[15:0]}};
            end
            2'd2: begin
                enc_size  = 2'd0;
                enc_wstrb = 4'b0001 << st_addr[1:0];
                enc_wdata = {4{st_data[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (AW+1)'(1);
        else if (pop && !push)
            count_nxt = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

    // Entry storage needs no reset: validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= st_addr;
            mem_size[wr_ptr]  <= enc_size;
            mem_wstrb[wr_ptr] <= enc_wstrb;
            mem_wdata[wr_ptr] <= enc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (count != '0)
                    state_nxt = REQ;
            REQ:
                if (data_addr_ok)
                    state_nxt = WAIT;
            WAIT:
                if (data_data_ok)
                    state_nxt = (count_nxt != '0) ? REQ : IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_req = (state == REQ);
        data_wr  = (state == REQ);
        busy     = (count != '0) || (state != IDLE);
    end

    // Payload is always the FIFO head, so it stays stable across a stall.
    assign data_addr  = mem_addr[rd_ptr];
    assign data_size  = mem_size[rd_ptr];
    assign data_wstrb = mem_wstrb[rd_ptr];
    assign data_wdata = mem_wdata[rd_ptr];

`ifdef STORE_UNIT_HAZARD_EN
    logic [AW-1:0] off;
    logic [1:0]    unused_ld_lo;

    assign unused_ld_lo = ld_addr[1:0];

    // An entry is live when its distance from the head is below count;
    // the in-flight head stays live until its data_data_ok pops it.
    always_comb begin
        ld_hazard = 1'b0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if (({1'b0, off} < count) &&
                (mem_addr[i][31:2] == ld_addr[31:2]))
                ld_hazard = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed checks of store_unit encoding, alignment,
// ordering, stall stability and reset behaviour.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ades;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        busy;
`ifdef STORE_UNIT_HAZARD_EN
    logic [31:0] ld_addr;
    logic        ld_hazard;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_unit #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_type      (st_type),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ades      (st_ades),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .busy         (busy)
`ifdef STORE_UNIT_HAZARD_EN
        ,
        .ld_addr      (ld_addr),
        .ld_hazard    (ld_hazard)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        st_valid     = 1'b0;
        st_type      = 2'd0;
        st_addr      = '0;
        st_data      = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
`ifdef STORE_UNIT_HAZARD_EN
        ld_addr      = '0;
`endif
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_req",   32'(data_req), 32'd0);
        chk("rst_wr",    32'(data_wr),  32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_ready", 32'(st_ready), 32'd1);

        // SB to byte lane 3
        st_valid = 1'b1;
        st_type  = 2'd2;
        st_addr  = 32'h0000_1003;
        st_data  = 32'h0000_00A5;
        #1;
        chk("sb_ades", 32'(st_ades), 32'd0);
        tick();
        st_valid = 1'b0;
        #1;
        chk("sb_req_lat", 32'(data_req), 32'd0);
        chk("sb_busy",    32'(busy),     32'd1);
        tick();
        chk("sb_req",   32'(data_req),   32'd1);
        chk("sb_wr",    32'(data_wr),    32'd1);
        chk("sb_strb",  32'(data_wstrb), 32'b1000);
        chk("sb_wdata", data_wdata,      32'hA5A5_A5A5);
        chk("sb_size",  32'(data_size),  32'd0);
        chk("sb_addr",  data_addr,       32'h0000_1003);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("sb_wait_req", 32'(data_req), 32'd0);
        chk("sb_wait_bsy", 32'(busy),     32'd1);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("sb_done_bsy", 32'(busy),     32'd0);
        chk("sb_done_rdy", 32'(st_ready), 32'd1);

        // misaligned requests
        st_valid = 1'b1;
        st_type  = 2'd0;
        st_addr  = 32'h0000_2002;
        #1;
        chk("sw_ades", 32'(st_ades), 32'd1);
        st_type = 2'd3;
        st_addr = 32'h0000_2001;
        #1;
        chk("rsv_ades", 32'(st_ades), 32'd1);
        st_type = 2'd1;
        st_addr = 32'h0000_1001;
        #1;
        chk("sh_ades", 32'(st_ades), 32'd1);
        tick();
        st_valid = 1'b0;
        #1;
        chk("sh_ades_req",  32'(data_req), 32'd0);
        chk("sh_ades_busy", 32'(busy),     32'd0);
        tick();
        chk("sh_ades_req2", 32'(data_req), 32'd0);

        // two SW, FIFO fills, then ordered issue
        st_valid = 1'b1;
        st_type  = 2'd0;
        st_addr  = 32'h0000_2000;
        st_data  = 32'h1122_3344;
        tick();
        st_addr = 32'h0000_2004;
        st_data = 32'h5566_7788;
        tick();
        st_valid = 1'b0;
        #1;
        chk("full_rdy", 32'(st_ready),   32'd0);
        chk("a_req",    32'(data_req),   32'd1);
        chk("a_addr",   data_addr,       32'h0000_2000);
        chk("a_wdata",  data_wdata,      32'h1122_3344);
        chk("a_strb",   32'(data_wstrb), 32'hF);
        chk("a_size",   32'(data_size),  32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req",   32'(data_req),   32'd1);
            chk("stall_addr",  data_addr,       32'h0000_2000);
            chk("stall_strb",  32'(data_wstrb), 32'hF);
            chk("stall_wdata", data_wdata,      32'h1122_3344);
        end
        // data_data_ok while in REQ is ignored
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("ign_dok_req",  32'(data_req), 32'd1);
        chk("ign_dok_addr", data_addr,     32'h0000_2000);
        chk("ign_dok_rdy",  32'(st_ready), 32'd0);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("a_wait_req", 32'(data_req), 32'd0);
        chk("a_wait_rdy", 32'(st_ready), 32'd0);
        // data_addr_ok while in WAIT is ignored
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("ign_aok_req", 32'(data_req), 32'd0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("b_rdy",   32'(st_ready), 32'd1);
        chk("b_req",   32'(data_req), 32'd1);
        chk("b_addr",  data_addr,     32'h0000_2004);
        chk("b_wdata", data_wdata,    32'h5566_7788);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("b_wait_req", 32'(data_req), 32'd0);
        chk("b_wait_bsy", 32'(busy),     32'd1);

        // reset while in WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_req",  32'(data_req), 32'd0);
        chk("mid_rst_busy", 32'(busy),     32'd0);
        chk("mid_rst_rdy",  32'(st_ready), 32'd1);
        tick();
        chk("mid_rst_req2", 32'(data_req), 32'd0);

        // SH to upper half
        st_valid = 1'b1;
        st_type  = 2'd1;
        st_addr  = 32'h0000_3006;
        st_data  = 32'h1234_BEEF;
        #1;
        chk("sh_ok_ades", 32'(st_ades), 32'd0);
        tick();
        st_valid = 1'b0;
        tick();
        chk("sh_req",   32'(data_req),   32'd1);
        chk("sh_strb",  32'(data_wstrb), 32'b1100);
        chk("sh_wdata", data_wdata,      32'hBEEF_BEEF);
        chk("sh_size",  32'(data_size),  32'd1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("sh_done_bsy", 32'(busy), 32'd0);

`ifdef STORE_UNIT_HAZARD_EN
        st_valid = 1'b1;
        st_type  = 2'd0;
        st_addr  = 32'h0000_2000;
        st_data  = 32'hCAFE_F00D;
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h0000_2002;
        #1;
        chk("hz_hit", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h0000_2004;
        #1;
        chk("hz_miss", 32'(ld_hazard), 32'd0);
        ld_addr = 32'h0000_2002;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("hz_wait", 32'(ld_hazard), 32'd1);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("hz_clr", 32'(ld_hazard), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
